// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {S_RUN, S_MULDIV, S_MEMWAIT} ctrl_state_t;

  // Bit positions of the per-register STALL/CLEAR vectors
  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;
  localparam int NUM_STG   = 4;

  function automatic int cnt_w(input int lat, input int tmo);
    int m;
    m = (lat > tmo) ? lat : tmo;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lu_hazard_det.sv
// Load-use hazard compare between the ID instruction's sources and a load in EX.
module lu_hazard_det #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  output logic              load_use
);

  logic rd_nz, hit1, hit2;

  // x0 is hardwired to zero, so a load targeting it never blocks a reader
  assign rd_nz    = |ex_rd;
  assign hit1     = id_use_rs1 & (id_rs1 == ex_rd);
  assign hit2     = id_use_rs2 & (id_rs2 == ex_rd);
  assign load_use = ex_is_load & rd_nz & (hit1 | hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use, MUL/DIV occupancy, DMEM wait with
// timeout, and branch/jump redirects, resolved in a fixed priority order.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT  = 8,
  parameter int MEM_TIMEOUT = 255,
  parameter int REG_AW      = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] ID_RS1,
  input  logic [REG_AW-1:0] ID_RS2,
  input  logic              ID_USE_RS1,
  input  logic              ID_USE_RS2,
  input  logic [REG_AW-1:0] EX_RD,
  input  logic              EX_IS_LOAD,
  input  logic              EX_IS_MULDIV,
  input  logic              EX_REDIRECT,
  input  logic              MEM_REQ,
  input  logic              DMEM_READY,
  output logic              PC_WE,
  output logic              STALL_IFID,
  output logic              STALL_IDEX,
  output logic              STALL_EXMEM,
  output logic              STALL_MEMWB,
  output logic              CLEAR_IFID,
  output logic              CLEAR_IDEX,
  output logic              CLEAR_EXMEM,
  output logic              CLEAR_MEMWB,
  output logic              BUS_ERR
);

  localparam int CW = cnt_w(MULDIV_LAT, MEM_TIMEOUT);
  localparam logic [CW-1:0] MD_LOAD  = CW'(MULDIV_LAT - 2);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

  ctrl_state_t        state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx, wcnt, wcnt_nx;
  logic               ret_md, ret_md_nx, bus_err_nx;
  logic               mem_wait, load_use, in_md, md_hold, pc_we;
  logic [NUM_STG-1:0] stall, clr;

  lu_hazard_det #(.REG_AW(REG_AW)) u_lu (
    .id_rs1     (ID_RS1),
    .id_rs2     (ID_RS2),
    .id_use_rs1 (ID_USE_RS1),
    .id_use_rs2 (ID_USE_RS2),
    .ex_rd      (EX_RD),
    .ex_is_load (EX_IS_LOAD),
    .load_use   (load_use)
  );

  assign mem_wait = MEM_REQ & ~DMEM_READY;
  // While waiting, behave as the state we will return to once DMEM is ready
  assign in_md    = (state == S_MULDIV) | ((state == S_MEMWAIT) & ret_md);
  assign md_hold  = in_md ? (cnt != '0) : EX_IS_MULDIV;

  always_comb begin
    pc_we = 1'b1;
    stall = '0;
    clr   = '0;
    if (mem_wait) begin
      pc_we            = 1'b0;
      stall[STG_IFID]  = 1'b1;
      stall[STG_IDEX]  = 1'b1;
      stall[STG_EXMEM] = 1'b1;
      clr[STG_MEMWB]   = 1'b1;
    end else if (md_hold) begin
      pc_we            = 1'b0;
      stall[STG_IFID]  = 1'b1;
      stall[STG_IDEX]  = 1'b1;
      clr[STG_EXMEM]   = 1'b1;
    end else if (EX_REDIRECT) begin
      clr[STG_IFID]    = 1'b1;
      clr[STG_IDEX]    = 1'b1;
    end else if (load_use) begin
      pc_we            = 1'b0;
      stall[STG_IFID]  = 1'b1;
      clr[STG_IDEX]    = 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    wcnt_nx    = wcnt;
    ret_md_nx  = ret_md;
    bus_err_nx = 1'b0;
    if (mem_wait) begin
      state_nx = S_MEMWAIT;
      if (state != S_MEMWAIT) ret_md_nx = (state == S_MULDIV);
      // wcnt is always 0 outside S_MEMWAIT, so the entry cycle counts as wait 1
      if (wcnt == TMO_LAST) begin
        bus_err_nx = 1'b1;
        wcnt_nx    = '0;
      end else begin
        wcnt_nx = wcnt + 1'b1;
      end
    end else begin
      wcnt_nx = '0;
      if (in_md) begin
        if (cnt == '0) begin
          state_nx = S_RUN;
        end else begin
          state_nx = S_MULDIV;
          cnt_nx   = cnt - 1'b1;
        end
      end else if (EX_IS_MULDIV) begin
        state_nx = S_MULDIV;
        cnt_nx   = MD_LOAD;
      end else begin
        state_nx = S_RUN;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_RUN;
      cnt     <= '0;
      wcnt    <= '0;
      ret_md  <= 1'b0;
      BUS_ERR <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      wcnt    <= wcnt_nx;
      ret_md  <= ret_md_nx;
      BUS_ERR <= bus_err_nx;
    end
  end

  assign PC_WE       = pc_we;
  assign STALL_IFID  = stall[STG_IFID];
  assign STALL_IDEX  = stall[STG_IDEX];
  assign STALL_EXMEM = stall[STG_EXMEM];
  assign STALL_MEMWB = stall[STG_MEMWB];
  assign CLEAR_IFID  = clr[STG_IFID];
  assign CLEAR_IDEX  = clr[STG_IDEX];
  assign CLEAR_EXMEM = clr[STG_EXMEM];
  assign CLEAR_MEMWB = clr[STG_MEMWB];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a
// count-based reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 8;
  localparam int TMO = 4;
  localparam int AW  = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] ID_RS1, ID_RS2, EX_RD;
  logic          ID_USE_RS1, ID_USE_RS2, EX_IS_LOAD, EX_IS_MULDIV, EX_REDIRECT;
  logic          MEM_REQ, DMEM_READY;
  logic          PC_WE, STALL_IFID, STALL_IDEX, STALL_EXMEM, STALL_MEMWB;
  logic          CLEAR_IFID, CLEAR_IDEX, CLEAR_EXMEM, CLEAR_MEMWB, BUS_ERR;
  logic [9:0]    obs;

  int errors = 0;
  int checks = 0;

  // Reference model: MUL/DIV progress as a count of EX cycles consumed,
  // DMEM wait as a run length of consecutive wait cycles.
  bit m_md_active;
  int m_md_done;
  int m_wcount;
  bit m_bus;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .MEM_TIMEOUT(TMO), .REG_AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
    .EX_RD(EX_RD), .EX_IS_LOAD(EX_IS_LOAD), .EX_IS_MULDIV(EX_IS_MULDIV),
    .EX_REDIRECT(EX_REDIRECT), .MEM_REQ(MEM_REQ), .DMEM_READY(DMEM_READY),
    .PC_WE(PC_WE), .STALL_IFID(STALL_IFID), .STALL_IDEX(STALL_IDEX),
    .STALL_EXMEM(STALL_EXMEM), .STALL_MEMWB(STALL_MEMWB),
    .CLEAR_IFID(CLEAR_IFID), .CLEAR_IDEX(CLEAR_IDEX), .CLEAR_EXMEM(CLEAR_EXMEM),
    .CLEAR_MEMWB(CLEAR_MEMWB), .BUS_ERR(BUS_ERR)
  );

  assign obs = {PC_WE, STALL_IFID, STALL_IDEX, STALL_EXMEM, STALL_MEMWB,
                CLEAR_IFID, CLEAR_IDEX, CLEAR_EXMEM, CLEAR_MEMWB, BUS_ERR};

  // st/cl ordered {IFID, IDEX, EXMEM, MEMWB}
  function automatic logic [9:0] mk(input logic pc, input logic [3:0] st,
                                    input logic [3:0] cl, input logic be);
    return {pc, st, cl, be};
  endfunction

  function automatic logic [9:0] model_exp();
    logic mw, lu, hold, pc;
    logic [3:0] st, cl;
    int done;
    mw   = MEM_REQ && !DMEM_READY;
    lu   = EX_IS_LOAD && (EX_RD != 0) &&
           ((ID_USE_RS1 && ID_RS1 == EX_RD) || (ID_USE_RS2 && ID_RS2 == EX_RD));
    done = m_md_active ? m_md_done : 0;
    hold = (m_md_active || EX_IS_MULDIV) && (done < LAT - 1);
    pc = 1'b1; st = 4'b0000; cl = 4'b0000;
    if (mw)               begin pc = 1'b0; st = 4'b1110; cl = 4'b0001; end
    else if (hold)        begin pc = 1'b0; st = 4'b1100; cl = 4'b0010; end
    else if (EX_REDIRECT) cl = 4'b1100;
    else if (lu)          begin pc = 1'b0; st = 4'b1000; cl = 4'b0100; end
    return {pc, st, cl, m_bus};
  endfunction

  task automatic model_step();
    bit mw, busy;
    int done;
    mw   = MEM_REQ && !DMEM_READY;
    busy = m_md_active || EX_IS_MULDIV;
    done = m_md_active ? m_md_done : 0;
    if (mw) begin
      m_wcount++;
      m_bus = (m_wcount % TMO) == 0;
    end else begin
      m_wcount = 0;
      m_bus    = 1'b0;
      if (busy) begin
        if (done == LAT - 1) m_md_active = 1'b0;
        else begin m_md_active = 1'b1; m_md_done = done + 1; end
      end
    end
  endtask

  task automatic model_reset();
    m_md_active = 1'b0; m_md_done = 0; m_wcount = 0; m_bus = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle();
    ID_RS1 = '0; ID_RS2 = '0; EX_RD = '0; ID_USE_RS1 = 0; ID_USE_RS2 = 0;
    EX_IS_LOAD = 0; EX_IS_MULDIV = 0; EX_REDIRECT = 0; MEM_REQ = 0; DMEM_READY = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1; idle(); model_reset();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs !== mk(1, 4'b0000, 4'b0000, 0)) begin
      errors++; $display("FAIL reset_idle: got %b want %b", obs, mk(1, 4'b0000, 4'b0000, 0));
    end
    tick();
    EX_IS_MULDIV = 1; tick(); tick();
    @(negedge CLK);
    #2 RST = 1'b1; EX_IS_MULDIV = 0; model_reset();
    #1 checks++;
    if (obs !== mk(1, 4'b0000, 4'b0000, 0)) begin
      errors++; $display("FAIL reset_async: got %b want %b", obs, mk(1, 4'b0000, 4'b0000, 0));
    end
    @(posedge CLK);
    #1 checks++;
    if (obs !== mk(1, 4'b0000, 4'b0000, 0)) begin
      errors++; $display("FAIL reset_held: got %b want %b", obs, mk(1, 4'b0000, 4'b0000, 0));
    end
    RST = 1'b0;
  endtask

  task automatic test_load_use();
    EX_IS_LOAD = 1; EX_RD = 5'd5; ID_RS1 = 5'd3; ID_RS2 = 5'd5; ID_USE_RS1 = 1; ID_USE_RS2 = 1;
    @(negedge CLK);
    checks++;
    if (obs !== mk(0, 4'b1000, 4'b0100, 0) || obs !== model_exp()) begin
      errors++; $display("FAIL load_use: got %b want %b", obs, mk(0, 4'b1000, 4'b0100, 0));
    end
    tick();
    EX_IS_LOAD = 0;
    @(negedge CLK);
    checks++;
    if (obs !== mk(1, 4'b0000, 4'b0000, 0)) begin
      errors++; $display("FAIL load_use_clear: got %b want %b", obs, mk(1, 4'b0000, 4'b0000, 0));
    end
    tick();
    EX_IS_LOAD = 1; EX_RD = '0; ID_RS2 = '0;
    @(negedge CLK);
    checks++;
    if (obs !== mk(1, 4'b0000, 4'b0000, 0)) begin
      errors++; $display("FAIL load_use_x0: got %b want %b", obs, mk(1, 4'b0000, 4'b0000, 0));
    end
    tick();
    idle();
  endtask

  task automatic test_muldiv();
    int holds = 0;
    EX_IS_MULDIV = 1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge CLK);
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL muldiv_cyc%0d: got %b want %b", i, obs, model_exp());
      end
      if (!PC_WE) holds++;
      tick();
    end
    EX_IS_MULDIV = 0;
    checks++;
    if (holds != LAT - 1) begin
      errors++; $display("FAIL muldiv_hold_len: got %0d want %0d", holds, LAT - 1);
    end
  endtask

  task automatic test_back_to_back();
    int holds = 0;
    int rel1 = -1;
    EX_IS_MULDIV = 1;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge CLK);
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL b2b_cyc%0d: got %b want %b", i, obs, model_exp());
      end
      if (!PC_WE) holds++;
      else if (rel1 < 0) rel1 = i;
      tick();
    end
    EX_IS_MULDIV = 0;
    checks++;
    if (holds != 2 * (LAT - 1) || rel1 != LAT - 1) begin
      errors++; $display("FAIL b2b_len: got holds=%0d rel=%0d want holds=%0d rel=%0d",
                         holds, rel1, 2 * (LAT - 1), LAT - 1);
    end
  endtask

  task automatic test_muldiv_memwait();
    int holds = 0;
    int rel = 0;
    EX_IS_MULDIV = 1;
    for (int i = 1; i <= 24; i++) begin
      MEM_REQ = (i >= 3 && i <= 6); DMEM_READY = 0;
      @(negedge CLK);
      checks++;
      if (obs !== model_exp() || (MEM_REQ && CLEAR_EXMEM)) begin
        errors++; $display("FAIL mdwait_cyc%0d: got %b want %b", i, obs, model_exp());
      end
      if (PC_WE) begin
        rel = i;
        tick();
        break;
      end
      holds++;
      tick();
    end
    idle();
    checks++;
    if (rel != LAT + 4 || holds != LAT - 1 + 4) begin
      errors++; $display("FAIL mdwait_len: got rel=%0d holds=%0d want rel=%0d holds=%0d",
                         rel, holds, LAT + 4, LAT - 1 + 4);
    end
  endtask

  task automatic test_redirect();
    EX_IS_LOAD = 1; EX_RD = 5'd7; ID_RS1 = 5'd7; ID_USE_RS1 = 1; EX_REDIRECT = 1;
    @(negedge CLK);
    checks++;
    if (obs !== mk(1, 4'b0000, 4'b1100, 0) || obs !== model_exp()) begin
      errors++; $display("FAIL redirect: got %b want %b", obs, mk(1, 4'b0000, 4'b1100, 0));
    end
    tick();
    MEM_REQ = 1; DMEM_READY = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (obs !== mk(0, 4'b1110, 4'b0001, 0) || obs !== model_exp()) begin
        errors++; $display("FAIL redirect_wait%0d: got %b want %b", i, obs, mk(0, 4'b1110, 4'b0001, 0));
      end
      tick();
    end
    DMEM_READY = 1;
    @(negedge CLK);
    checks++;
    if (obs !== mk(1, 4'b0000, 4'b1100, 0) || obs !== model_exp()) begin
      errors++; $display("FAIL redirect_ready: got %b want %b", obs, mk(1, 4'b0000, 4'b1100, 0));
    end
    tick();
    idle();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int first = 0;
    MEM_REQ = 1; DMEM_READY = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL timeout_cyc%0d: got %b want %b", i, obs, model_exp());
      end
      if (BUS_ERR) begin
        pulses++;
        if (first == 0) first = i;
      end
      tick();
    end
    checks++;
    if (pulses != 2 || first != TMO + 1) begin
      errors++; $display("FAIL timeout_pulses: got n=%0d first=%0d want n=2 first=%0d",
                         pulses, first, TMO + 1);
    end
    DMEM_READY = 1;
    @(negedge CLK);
    checks++;
    if (obs !== mk(1, 4'b0000, 4'b0000, 0)) begin
      errors++; $display("FAIL timeout_ready: got %b want %b", obs, mk(1, 4'b0000, 4'b0000, 0));
    end
    tick();
    idle();
    @(negedge CLK);
    checks++;
    if (obs !== mk(1, 4'b0000, 4'b0000, 0)) begin
      errors++; $display("FAIL timeout_run: got %b want %b", obs, mk(1, 4'b0000, 4'b0000, 0));
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ID_RS1       = AW'($urandom_range(0, 3));
      ID_RS2       = AW'($urandom_range(0, 3));
      EX_RD        = AW'($urandom_range(0, 3));
      ID_USE_RS1   = $urandom_range(0, 1) == 1;
      ID_USE_RS2   = $urandom_range(0, 1) == 1;
      EX_IS_LOAD   = $urandom_range(0, 2) == 0;
      EX_IS_MULDIV = $urandom_range(0, 9) == 0;
      EX_REDIRECT  = $urandom_range(0, 4) == 0;
      MEM_REQ      = $urandom_range(0, 3) == 0;
      DMEM_READY   = $urandom_range(0, 2) == 0;
      @(negedge CLK);
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL random_cyc%0d: got %b want %b", i, obs, model_exp());
      end
      tick();
    end
    idle();
    repeat (LAT + 2) tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_back_to_back();
    test_muldiv_memwait();
    test_redirect();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
